// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV base opcodes, one-hot class bit positions,
// the M-extension func7 tag and the packed payload of decoded fields.
package decode_stage_pkg;

   // Base opcodes, instr[6:0]
   localparam logic [6:0] I_TYPE     = 7'b0010011;
   localparam logic [6:0] L_TYPE     = 7'b0000011;
   localparam logic [6:0] S_TYPE     = 7'b0100011;
   localparam logic [6:0] R_TYPE     = 7'b0110011;
   localparam logic [6:0] JAL_TYPE   = 7'b1101111;
   localparam logic [6:0] JALR_TYPE  = 7'b1100111;
   localparam logic [6:0] LUI_TYPE   = 7'b0110111;
   localparam logic [6:0] AUIPC_TYPE = 7'b0010111;
   localparam logic [6:0] B_TYPE     = 7'b1100011;

   // Bit positions inside the one-hot class vector
   localparam int unsigned CLS_I     = 0;
   localparam int unsigned CLS_L     = 1;
   localparam int unsigned CLS_S     = 2;
   localparam int unsigned CLS_R     = 3;
   localparam int unsigned CLS_JAL   = 4;
   localparam int unsigned CLS_JALR  = 5;
   localparam int unsigned CLS_LUI   = 6;
   localparam int unsigned CLS_AUIPC = 7;
   localparam int unsigned CLS_B     = 8;
   localparam int unsigned CLS_W     = 9;

   localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

   // XLEN-independent part of a decoded instruction
   typedef struct packed {
      logic [2:0]       func3;
      logic             func7;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [CLS_W-1:0] cls;
      logic             mul;
      logic             illegal;
   } dec_fields_t;

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I/RV64I field decoder.
//   instr  : 32-bit instruction word
//   fields : func3/func7/rs1/rs2/rd/class/mul/illegal
//   imme   : sign-extended immediate at XLEN, 0 for R-type and illegal
module rv_decode_comb
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter bit          RVM_EN = 1'b1
) (
   input  logic [31:0]     instr,
   output dec_fields_t     fields,
   output logic [XLEN-1:0] imme
);

   logic [31:0] imm32;
   logic        use_rs1;
   logic        use_rs2;

   // Class, operand-use and 32-bit immediate selection
   always_comb begin
      fields       = '0;
      imm32        = '0;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
      fields.func3 = instr[14:12];
      fields.func7 = instr[30];
      fields.rd    = instr[11:7];
      if (instr[1:0] != 2'b11) begin
         fields.illegal = 1'b1;
      end else begin
         case (instr[6:0])
            I_TYPE: begin
               fields.cls[CLS_I] = 1'b1;
               use_rs1 = 1'b1;
               imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            L_TYPE: begin
               fields.cls[CLS_L] = 1'b1;
               use_rs1 = 1'b1;
               imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            S_TYPE: begin
               fields.cls[CLS_S] = 1'b1;
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            R_TYPE: begin
               fields.cls[CLS_R] = 1'b1;
               use_rs1    = 1'b1;
               use_rs2    = 1'b1;
               fields.mul = RVM_EN && (instr[31:25] == FUNC7_MULDIV);
            end
            JAL_TYPE: begin
               fields.cls[CLS_JAL] = 1'b1;
               imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
            end
            JALR_TYPE: begin
               fields.cls[CLS_JALR] = 1'b1;
               use_rs1 = 1'b1;
               imm32   = {{20{instr[31]}}, instr[31:20]};
            end
            LUI_TYPE: begin
               fields.cls[CLS_LUI] = 1'b1;
               imm32 = {instr[31:12], 12'b0};
            end
            AUIPC_TYPE: begin
               fields.cls[CLS_AUIPC] = 1'b1;
               imm32 = {instr[31:12], 12'b0};
            end
            B_TYPE: begin
               fields.cls[CLS_B] = 1'b1;
               use_rs1 = 1'b1;
               use_rs2 = 1'b1;
               imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            end
            default: fields.illegal = 1'b1;
         endcase
      end
      fields.rs1 = use_rs1 ? instr[19:15] : 5'd0;
      fields.rs2 = use_rs2 ? instr[24:20] : 5'd0;
   end

   // Signed cast widens with instr[31] replicated up to XLEN
   assign imme = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: instruction queue, head decoder, output register.
//   clk, rst_n            : clock, asynchronous active-low reset
//   if_valid/if_ready     : fetch handshake, with if_instr and if_pc
//   flush                 : synchronous kill of queue and output register
//   id_valid/id_ready     : execute handshake
//   id_pc .. id_illegal   : registered decode results
//   q_count               : queue occupancy
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned QDEPTH = 2,
   parameter bit          RVM_EN = 1'b1,
   localparam int unsigned CW    = $clog2(QDEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [31:0]      if_instr,
   input  logic [XLEN-1:0]  if_pc,
   input  logic             flush,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [XLEN-1:0]  id_pc,
   output logic [2:0]       id_func3,
   output logic             id_func7,
   output logic [4:0]       id_rs1,
   output logic [4:0]       id_rs2,
   output logic [4:0]       id_rd,
   output logic [XLEN-1:0]  id_imme,
   output logic [CLS_W-1:0] id_class,
   output logic             id_mul,
   output logic             id_illegal,
   output logic [CW-1:0]    q_count
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [XLEN-1:0] pc_mem    [QDEPTH];
   logic [31:0]     instr_mem [QDEPTH];
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            load;
   dec_fields_t     dec_c;
   logic [XLEN-1:0] imme_c;
   dec_fields_t     dec_q;

   // Circular pointer advance for non-power-of-two depths
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Acceptance uses registered count only
   assign if_ready = (count < CW'(QDEPTH));
   assign push     = if_valid && if_ready;
   assign load     = (count != '0) && (!id_valid || id_ready);
   assign q_count  = count;

   rv_decode_comb #(
      .XLEN   (XLEN),
      .RVM_EN (RVM_EN)
   ) u_dec (
      .instr  (instr_mem[rptr]),
      .fields (dec_c),
      .imme   (imme_c)
   );

   // Queue storage; flush discards a same-cycle push through wptr/count
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[wptr]    <= if_pc;
         instr_mem[wptr] <= if_instr;
      end
   end

   // Pointers, occupancy and output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_imme  <= '0;
         dec_q    <= '0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_imme  <= '0;
         dec_q    <= '0;
      end else begin
         if (push) begin
            wptr <= ptr_inc(wptr);
         end
         if (load) begin
            rptr     <= ptr_inc(rptr);
            id_valid <= 1'b1;
            id_pc    <= pc_mem[rptr];
            id_imme  <= imme_c;
            dec_q    <= dec_c;
         end else if (id_ready) begin
            id_valid <= 1'b0;
         end
         case ({push, load})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign id_func3   = dec_q.func3;
   assign id_func7   = dec_q.func7;
   assign id_rs1     = dec_q.rs1;
   assign id_rs2     = dec_q.rs2;
   assign id_rd      = dec_q.rd;
   assign id_class   = dec_q.cls;
   assign id_mul     = dec_q.mul;
   assign id_illegal = dec_q.illegal;

endmodule
